// File: rtl/vx_pipeline_perf_reader.sv
// Snapshot-and-read front end for the twelve pipeline perf counters; serves 32-bit words over valid/ready.
// Optional feature macro: PERF_SNAPSHOT_EN (coherent shadow snapshot). Without it, reads sample the live counters.
module vx_pipeline_perf_reader #(
    parameter int CTR_BITS = 44
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [12*CTR_BITS-1:0]   perf_counters,
    input  logic                     snap_req,
    output logic                     snap_valid,
    output logic [7:0]               snap_count,
    input  logic                     req_valid,
    input  logic [4:0]               req_addr,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    input  logic                     rsp_ready,
    output logic                     o_dbg_state
);

    // Handshake: a request transfers on the edge where req_valid && req_ready;
    // a response transfers on the edge where rsp_valid && rsp_ready. Payloads are held while valid is up.
    typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     w_accept;
    logic [12*CTR_BITS-1:0]   w_src;
    logic [3:0]               w_idx;
    logic                     w_err;
    logic [CTR_BITS-1:0]      w_ctr;
    logic [63:0]              w_ctr64;
    logic [31:0]              w_word;
    logic [31:0]              r_rsp_data;
    logic                     r_rsp_err;

`ifdef PERF_SNAPSHOT_EN
    logic [12*CTR_BITS-1:0]   r_shadow;
    logic                     r_snap_valid;
    logic [7:0]               r_snap_count;

    // All shadows load on one edge so a snapshot is coherent across counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow     <= '0;
            r_snap_valid <= 1'b0;
            r_snap_count <= 8'd0;
        end else if (snap_req) begin
            r_shadow     <= perf_counters;
            r_snap_valid <= 1'b1;
            r_snap_count <= r_snap_count + 8'd1;
        end
    end

    assign w_src      = r_shadow;
    assign snap_valid = r_snap_valid;
    assign snap_count = r_snap_count;
`else
    logic w_unused_snap_req;

    assign w_unused_snap_req = snap_req;
    assign w_src      = perf_counters;
    assign snap_valid = 1'b0;
    assign snap_count = 8'd0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_next_state = ST_RESP;
            ST_RESP: if (rsp_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (r_state == ST_IDLE);
        rsp_valid   = (r_state == ST_RESP);
        o_dbg_state = r_state;
    end

    assign w_accept = req_valid && req_ready;
    assign w_idx    = req_addr[4:1];
    assign w_err    = (w_idx >= 4'd12);

    always_comb begin
        w_ctr = '0;
        for (int i = 0; i < 12; i++) begin
            if (w_idx == 4'(i)) w_ctr = w_src[i*CTR_BITS +: CTR_BITS];
        end
    end

    // Widening to 64 bits zero-fills the high word for any CTR_BITS below 64.
    assign w_ctr64 = 64'(w_ctr);
    assign w_word  = req_addr[0] ? w_ctr64[63:32] : w_ctr64[31:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 1'b0;
        end else if (w_accept) begin
            r_rsp_data <= w_err ? 32'd0 : w_word;
            r_rsp_err  <= w_err;
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_vx_pipeline_perf_reader.sv
// Directed bench for vx_pipeline_perf_reader: vector table for word/error decode plus
// hand-written sequences for snapshot collision, backpressure, counter wrap and async reset.
module tb_vx_pipeline_perf_reader;

    localparam int CB = 44;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic                 clk;
    logic                 reset;
    logic [12*CB-1:0]     perf_counters;
    logic                 snap_req;
    logic                 snap_valid;
    logic [7:0]           snap_count;
    logic                 req_valid;
    logic [4:0]           req_addr;
    logic                 req_ready;
    logic                 rsp_valid;
    logic [31:0]          rsp_data;
    logic                 rsp_err;
    logic                 rsp_ready;
    logic                 dbg_state;

    int   n_checks;
    int   n_errors;
    logic [7:0] exp_cnt;
    logic       exp_snap_valid;
    vec_t vecs[12];

    vx_pipeline_perf_reader #(.CTR_BITS(CB)) dut (
        .clk           (clk),
        .reset         (reset),
        .perf_counters (perf_counters),
        .snap_req      (snap_req),
        .snap_valid    (snap_valid),
        .snap_count    (snap_count),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .rsp_ready     (rsp_ready),
        .o_dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_ctr(input int idx, input logic [CB-1:0] val);
        perf_counters[idx*CB +: CB] = val;
    endtask

    // One snapshot pulse; the expected count/valid model follows the build option.
    task automatic pulse_snap();
        @(negedge clk);
        snap_req = 1'b1;
        @(posedge clk);
        #1 snap_req = 1'b0;
`ifdef PERF_SNAPSHOT_EN
        exp_cnt        = exp_cnt + 8'd1;
        exp_snap_valid = 1'b1;
`endif
    endtask

    // Full read transaction; optional snap pulse on the accept edge and rsp_ready held low for 'hold' cycles.
    task automatic do_read(input string name, input logic [4:0] addr, input logic snap,
                           input int hold, input logic [31:0] exp_data, input logic exp_err);
        @(negedge clk);
        check({name, " req_ready before accept"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = addr;
        snap_req  = snap;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        snap_req  = 1'b0;
`ifdef PERF_SNAPSHOT_EN
        if (snap) begin
            exp_cnt        = exp_cnt + 8'd1;
            exp_snap_valid = 1'b1;
        end
`endif
        check({name, " rsp_valid"}, rsp_valid, 1'b1);
        check({name, " rsp_data"}, rsp_data, exp_data);
        check({name, " rsp_err"}, rsp_err, exp_err);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            check({name, " hold rsp_valid"}, rsp_valid, 1'b1);
            check({name, " hold req_ready"}, req_ready, 1'b0);
            check({name, " hold rsp_data"}, rsp_data, exp_data);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({name, " back to idle rsp_valid"}, rsp_valid, 1'b0);
        check({name, " back to idle req_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        exp_cnt        = 8'd0;
        exp_snap_valid = 1'b0;
        reset          = 1'b1;
        perf_counters  = '0;
        snap_req       = 1'b0;
        req_valid      = 1'b0;
        req_addr       = 5'd0;
        rsp_ready      = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset req_ready", req_ready, 1'b1);
        check("reset rsp_valid", rsp_valid, 1'b0);
        check("reset rsp_data", rsp_data, 32'd0);
        check("reset rsp_err", rsp_err, 1'b0);
        check("reset snap_valid", snap_valid, 1'b0);
        check("reset snap_count", snap_count, 8'd0);

        do_read("read before snapshot", 5'h00, 1'b0, 0, 32'd0, 1'b0);

        // Counter i = {A00|i, 0x11111111*(i+1)}, loads = 0x123_456789AB.
        for (int i = 0; i < 12; i++) begin
            set_ctr(i, {12'hA00 | 12'(i), 32'h1111_1111 * 32'(i + 1)});
        end
        set_ctr(8, 44'h123_4567_89AB);
        pulse_snap();
        check("snap_count after 1 pulse", snap_count, exp_cnt);
        check("snap_valid after 1 pulse", snap_valid, exp_snap_valid);
        set_ctr(8, 44'hFED_CBA9_8765);

        vecs[0]  = '{5'h00, 32'h1111_1111, 1'b0};
        vecs[1]  = '{5'h01, 32'h0000_0A00, 1'b0};
        vecs[2]  = '{5'h07, 32'h0000_0A03, 1'b0};
        vecs[3]  = '{5'h0A, 32'h6666_6666, 1'b0};
`ifdef PERF_SNAPSHOT_EN
        vecs[4]  = '{5'h10, 32'h4567_89AB, 1'b0};
        vecs[5]  = '{5'h11, 32'h0000_0123, 1'b0};
`else
        vecs[4]  = '{5'h10, 32'hCBA9_8765, 1'b0};
        vecs[5]  = '{5'h11, 32'h0000_0FED, 1'b0};
`endif
        vecs[6]  = '{5'h16, 32'hCCCC_CCCC, 1'b0};
        vecs[7]  = '{5'h17, 32'h0000_0A0B, 1'b0};
        vecs[8]  = '{5'h18, 32'h0000_0000, 1'b1};
        vecs[9]  = '{5'h19, 32'h0000_0000, 1'b1};
        vecs[10] = '{5'h1F, 32'h0000_0000, 1'b1};
        vecs[11] = '{5'h0E, 32'h8888_8888, 1'b0};

        for (int v = 0; v < 12; v++) begin
            do_read($sformatf("vec%0d addr 0x%0h", v, vecs[v].addr), vecs[v].addr, 1'b0, 0,
                    vecs[v].exp_data, vecs[v].exp_err);
        end

        // Snapshot on the accept edge: the response still reflects the previous shadow.
        set_ctr(0, 44'h777_0000_1234);
`ifdef PERF_SNAPSHOT_EN
        do_read("collide read", 5'h00, 1'b1, 0, 32'h1111_1111, 1'b0);
`else
        do_read("collide read", 5'h00, 1'b1, 0, 32'h0000_1234, 1'b0);
`endif
        do_read("after collide read", 5'h00, 1'b0, 0, 32'h0000_1234, 1'b0);
        check("snap_count after collide", snap_count, exp_cnt);

        do_read("backpressure", 5'h11, 1'b0, 5, 32'h0000_0FED, 1'b0);

        for (int p = 0; p < 256; p++) begin
            pulse_snap();
            if (exp_cnt == 8'd0) check("snap_count at wrap", snap_count, exp_cnt);
        end
        check("snap_count after 256 pulses", snap_count, exp_cnt);
        check("snap_valid after pulses", snap_valid, exp_snap_valid);

        // Reset in RESP must drop the response without a clock edge.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 5'h01;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("pre-reset rsp_valid", rsp_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async reset rsp_valid", rsp_valid, 1'b0);
        check("async reset rsp_data", rsp_data, 32'd0);
        check("async reset snap_count", snap_count, 8'd0);
        check("async reset snap_valid", snap_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post reset req_ready", req_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
